bsg_wormhole_link_2to1_arbiter: RTL and testbench
=================================================

# bsg_wormhole_link_2to1_arbiter

Packet-atomic 2:1 arbiter that merges two wormhole ready/valid flit streams into one link feeding a chip IO complex input channel. It holds a grant for a whole wormhole packet (header plus `len` body flits) so flits of different packets never interleave. Output is a zero-latency combinational pass-through; arbitration state, a body-flit counter and a round-robin pointer are registered. Sits between the processor or bypass-router link outputs and the `links_i` input of the IO complex.

## Interface
Parameters:
- `flit_width_p`, 64: flit width in bits.
- `cord_width_p`, 8: width of destination-cord field at flit bits `[cord_width_p-1:0]`.
- `len_width_p`, 4: width of packet-length field at bits `[cord_width_p+len_width_p-1:cord_width_p]`; value = number of body flits after the header.

Ports:
- `clk_i`  in  1  sole clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `a_v_i`  in  1  input A flit valid.
- `a_data_i`  in  `flit_width_p`  input A flit.
- `a_ready_and_o`  out  1  input A ready.
- `b_v_i`, `b_data_i`, `b_ready_and_o`: same as A, for input B.
- `v_o`  out  1  merged flit valid.
- `data_o`  out  `flit_width_p`  merged flit.
- `ready_and_i`  in  1  downstream ready.
- `a_pkts_o`, `b_pkts_o`  out  16 each  packet counters; present only with `BSG_WH_ARB_STATS_EN`.

## Operation
- Transfer on a port happens when its valid and ready are both 1 in the same cycle.
- State: IDLE or BUSY; `grant_r` (0=A, 1=B); `cnt_r` (`len_width_p` bits); `prio_r` (0=A preferred).
- IDLE: candidate = `prio_r` input if its valid is 1, else the other input if its valid is 1, else none. Candidate's valid and data go to `v_o`/`data_o`. Candidate's ready = `ready_and_i`. Other ready = 0.
- IDLE header transfer with len==0: stay IDLE and set `prio_r` = other input.
- IDLE header transfer with len>0: go BUSY, `grant_r`=candidate, `cnt_r`=len.
- BUSY: only the granted input is connected (valid, data, ready). The other input's ready = 0. Each transfer decrements `cnt_r`.
- BUSY transfer with `cnt_r`==1: return to IDLE and set `prio_r` = other input.
- Granted input deasserting valid mid-packet: `v_o`=0, state held. No timeout, no abort.
- Length is read only from the header flit. Body-flit contents are never inspected.
- Only `cnt_r` decrements, never below 1 in BUSY, so no wrap-around; len = 2^len_width_p−1 is supported.

## Timing
- Zero-cycle latency: `data_o`/`v_o` depend combinationally on the selected input. `*_ready_and_o` depend combinationally on `ready_and_i` and state.
- No combinational path from `ready_and_i` to `v_o`.
- Throughput: 1 flit/cycle. Back-to-back packets from alternating inputs incur no bubble.
- During `reset_i`=1: `v_o`=0, `a_ready_and_o`=`b_ready_and_o`=0, `data_o` don't-care.
- Next edge after reset: state=IDLE, `cnt_r`=0, `prio_r`=0, stats counters=0.
- Reset asserted mid-packet: the partial packet is dropped from arbiter state. The upstream module is reset in the same domain.

## Configuration
- `BSG_WH_ARB_STATS_EN` defined: adds `a_pkts_o`/`b_pkts_o`. Each counter increments on its input's header transfer and saturates at 16'hFFFF. Reset value 0.
- `BSG_WH_ARB_STATS_EN` undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- After reset, A sends a header with len=0 while B is idle. Required: `v_o`=1, `data_o`=A flit, `prio_r`→B; a_pkts=1 when stats are enabled.
- A and B both present headers with len=2 in the same cycle after reset, `ready_and_i`=1. Required: `data_o` carries A header, A0, A1, B header, B0, B1 in 6 consecutive cycles; `b_ready_and_o`=0 for the first 3 cycles.
- A packet with len=3: `a_v_i` dropped for 2 cycles after the first body flit while B is valid. Required: `v_o`=0 in those cycles; B is not granted until A's last body flit transfers.
- `ready_and_i` toggles 1,0,1,0 during a B len=1 packet. Required: exactly 2 transfers, no duplicated or lost flit, then IDLE with `prio_r`=A.
- Reset asserted in BUSY with `cnt_r`=5. Required: readies and `v_o` are 0 during reset; afterward a fresh A len=0 header passes immediately.
- Stats enabled: 70000 back-to-back len=0 headers from A. Required: `a_pkts_o` saturates at 65535 and `b_pkts_o` stays 0.

Source files
------------

// File: rtl/bsg_wormhole_link_2to1_arbiter.sv
// Packet-atomic 2:1 wormhole link arbiter with a combinational flit path and round-robin
// fairness between packets. Define BSG_WH_ARB_STATS_EN to add per-input packet counters.
module bsg_wormhole_link_2to1_arbiter #(
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 8,
    parameter int len_width_p  = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic                    a_v_i,
    input  logic [flit_width_p-1:0] a_data_i,
    output logic                    a_ready_and_o,

    input  logic                    b_v_i,
    input  logic [flit_width_p-1:0] b_data_i,
    output logic                    b_ready_and_o,

    output logic                    v_o,
    output logic [flit_width_p-1:0] data_o,
    input  logic                    ready_and_i
`ifdef BSG_WH_ARB_STATS_EN
    ,
    output logic [15:0]             a_pkts_o,
    output logic [15:0]             b_pkts_o
`endif
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                 state_r, state_n;
    logic                   grant_r, grant_n;
    logic                   prio_r, prio_n;
    logic [len_width_p-1:0] cnt_r, cnt_n;

    logic                   sel;
    logic                   xfer;
    logic [len_width_p-1:0] hdr_len;

    // sel picks the input whose valid/data/ready are routed to the link (0=A, 1=B)
    always_comb begin
        sel = grant_r;
        if (state_r == StIdle) begin
            if (prio_r) sel = b_v_i || !a_v_i;
            else        sel = b_v_i && !a_v_i;
        end
    end

    assign data_o        = sel ? b_data_i : a_data_i;
    assign v_o           = !reset_i && (sel ? b_v_i : a_v_i);
    assign a_ready_and_o = !reset_i && ready_and_i && !sel && (state_r == StBusy || a_v_i);
    assign b_ready_and_o = !reset_i && ready_and_i &&  sel && (state_r == StBusy || b_v_i);
    assign xfer          = v_o && ready_and_i;
    assign hdr_len       = data_o[cord_width_p+len_width_p-1:cord_width_p];

    always_comb begin
        state_n = state_r;
        grant_n = grant_r;
        prio_n  = prio_r;
        cnt_n   = cnt_r;
        unique case (state_r)
            StIdle: begin
                if (xfer) begin
                    if (hdr_len == '0) begin
                        prio_n = !sel;
                    end else begin
                        state_n = StBusy;
                        grant_n = sel;
                        cnt_n   = hdr_len;
                    end
                end
            end
            StBusy: begin
                if (xfer) begin
                    cnt_n = cnt_r - 1'b1;
                    if (cnt_r == len_width_p'(1)) begin
                        state_n = StIdle;
                        prio_n  = !grant_r;
                    end
                end
            end
            default: state_n = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= StIdle;
            grant_r <= 1'b0;
            prio_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            grant_r <= grant_n;
            prio_r  <= prio_n;
            cnt_r   <= cnt_n;
        end
    end

`ifdef BSG_WH_ARB_STATS_EN
    logic [15:0] a_pkts_r, b_pkts_r;
    logic        hdr_xfer;

    assign hdr_xfer = xfer && (state_r == StIdle);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_pkts_r <= '0;
            b_pkts_r <= '0;
        end else if (hdr_xfer) begin
            if (!sel && a_pkts_r != 16'hFFFF) a_pkts_r <= a_pkts_r + 16'd1;
            if ( sel && b_pkts_r != 16'hFFFF) b_pkts_r <= b_pkts_r + 16'd1;
        end
    end

    assign a_pkts_o = a_pkts_r;
    assign b_pkts_o = b_pkts_r;
`endif

endmodule

// File: tb/tb_bsg_wormhole_link_2to1_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a packet-level model.
module tb_bsg_wormhole_link_2to1_arbiter;

    localparam int FW = 64;
    localparam int CW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_v, b_v, rdy;
    logic [FW-1:0] a_d, b_d, data;
    logic          a_r, b_r, v;
`ifdef BSG_WH_ARB_STATS_EN
    logic [15:0]   a_pkts, b_pkts;
`endif

    always #5 clk = ~clk;

    bsg_wormhole_link_2to1_arbiter #(
        .flit_width_p(FW),
        .cord_width_p(CW),
        .len_width_p (LW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .a_v_i        (a_v),
        .a_data_i     (a_d),
        .a_ready_and_o(a_r),
        .b_v_i        (b_v),
        .b_data_i     (b_d),
        .b_ready_and_o(b_r),
        .v_o          (v),
        .data_o       (data),
        .ready_and_i  (rdy)
`ifdef BSG_WH_ARB_STATS_EN
        ,
        .a_pkts_o     (a_pkts),
        .b_pkts_o     (b_pkts)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Upstream flit queues and the packet-level reference model
    logic [FW-1:0] q[2][$];
    int owner = -1;   // input owning an in-flight packet, -1 when none
    int left  = 0;    // body flits of that packet still to pass
    int pref  = 0;    // input favoured for the next packet
    int pk[2] = '{0, 0};

    function automatic logic [FW-1:0] rnd_flit();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [FW-1:0] push_pkt(input int side, input int len);
        logic [FW-1:0] h;
        h = rnd_flit();
        h[CW+LW-1:CW] = LW'(len);
        q[side].push_back(h);
        for (int i = 0; i < len; i++) q[side].push_back(rnd_flit());
        return h;
    endfunction

    // One cycle: drive queue heads, compare DUT against the model, advance the model
    task automatic step(input logic want_a, input logic want_b, input logic r,
                        output logic xf, output logic [FW-1:0] flit);
        logic          vv[2];
        logic [FW-1:0] dd[2];
        int            cand;
        int            len;
        logic          ev;
        @(negedge clk);
        reset = 1'b0;
        vv[0] = want_a && q[0].size() > 0;
        vv[1] = want_b && q[1].size() > 0;
        dd[0] = (q[0].size() > 0) ? q[0][0] : rnd_flit();
        dd[1] = (q[1].size() > 0) ? q[1][0] : rnd_flit();
        a_v = vv[0]; a_d = dd[0];
        b_v = vv[1]; b_d = dd[1];
        rdy = r;
        #1;
        if (owner >= 0)         cand = owner;
        else if (vv[pref])      cand = pref;
        else if (vv[1 - pref])  cand = 1 - pref;
        else                    cand = -1;
        ev = (cand >= 0) ? vv[cand] : 1'b0;
        check("v_o", 64'(v), 64'(ev));
        check("a_ready", 64'(a_r), 64'(cand == 0 && r));
        check("b_ready", 64'(b_r), 64'(cand == 1 && r));
        if (ev) check("data_o", data, dd[cand]);
`ifdef BSG_WH_ARB_STATS_EN
        check("a_pkts", 64'(a_pkts), 64'((pk[0] > 65535) ? 65535 : pk[0]));
        check("b_pkts", 64'(b_pkts), 64'((pk[1] > 65535) ? 65535 : pk[1]));
`endif
        xf   = ev && r;
        flit = (cand >= 0) ? dd[cand] : '0;
        if (xf) begin
            void'(q[cand].pop_front());
            if (owner < 0) begin
                pk[cand]++;
                len = int'(flit[CW+LW-1:CW]);
                if (len == 0) pref = 1 - cand;
                else begin
                    owner = cand;
                    left  = len;
                end
            end else begin
                left--;
                if (left == 0) begin
                    owner = -1;
                    pref  = 1 - cand;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        a_v = 1'b1; a_d = rnd_flit();
        b_v = 1'b1; b_d = rnd_flit();
        rdy = 1'b1;
        #1;
        check("rst_v_o", 64'(v), 64'd0);
        check("rst_a_ready", 64'(a_r), 64'd0);
        check("rst_b_ready", 64'(b_r), 64'd0);
        q[0].delete();
        q[1].delete();
        owner = -1; left = 0; pref = 0;
        pk[0] = 0; pk[1] = 0;
    endtask

    initial begin
        logic          xf;
        logic [FW-1:0] f, ha, hb;
        logic [FW-1:0] seq[$];
        int            n;

        reset = 1'b1; a_v = 0; b_v = 0; rdy = 0; a_d = '0; b_d = '0;
        do_reset();

        // A len=0 header alone passes at once; priority then moves to B
        ha = push_pkt(0, 0);
        step(1, 0, 1, xf, f);
        check("t1_xfer", 64'(xf), 64'd1);
        check("t1_flit", f, ha);
        ha = push_pkt(0, 0);
        hb = push_pkt(1, 0);
        step(1, 1, 1, xf, f);
        check("t1_prio_b", f, hb);
        step(1, 1, 1, xf, f);
        check("t1_then_a", f, ha);

        // Simultaneous len=2 packets: A wins fully, then B, no bubble
        do_reset();
        void'(push_pkt(0, 2));
        void'(push_pkt(1, 2));
        seq = {q[0], q[1]};
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 1, xf, f);
            check($sformatf("t2_flit%0d", i), f, seq[i]);
            if (i < 3) check($sformatf("t2_b_ready%0d", i), 64'(b_r), 64'd0);
        end

        // A len=3 stalls mid-packet; B must wait until A's last body flit
        do_reset();
        void'(push_pkt(0, 3));
        hb = push_pkt(1, 0);
        step(1, 1, 1, xf, f);
        step(1, 1, 1, xf, f);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 1, xf, f);
            check("t3_stall_v", 64'(v), 64'd0);
        end
        step(1, 1, 1, xf, f);
        step(1, 1, 1, xf, f);
        check("t3_a_done", 64'(q[0].size()), 64'd0);
        step(1, 1, 1, xf, f);
        check("t3_b_hdr", f, hb);

        // B len=1 under ready toggling: exactly two transfers, then A preferred
        do_reset();
        void'(push_pkt(1, 1));
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, (i % 2) == 0, xf, f);
            if (xf) n++;
        end
        check("t4_xfers", 64'(n), 64'd2);
        ha = push_pkt(0, 0);
        hb = push_pkt(1, 0);
        step(1, 1, 1, xf, f);
        check("t4_prio_a", f, ha);

        // Reset in BUSY with five body flits remaining
        do_reset();
        void'(push_pkt(0, 7));
        for (int i = 0; i < 3; i++) step(1, 0, 1, xf, f);
        do_reset();
        ha = push_pkt(0, 0);
        step(1, 0, 1, xf, f);
        check("t5_fresh_xfer", 64'(xf), 64'd1);
        check("t5_fresh_flit", f, ha);

        // Randomized mixed traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int s = 0; s < 2; s++)
                if (q[s].size() < 4)
                    void'(push_pkt(s, ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3)));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, xf, f);
        end

`ifdef BSG_WH_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            void'(push_pkt(0, 0));
            step(1, 0, 1, xf, f);
        end
        step(0, 0, 1, xf, f);
        check("sat_a_pkts", 64'(a_pkts), 64'd65535);
        check("sat_b_pkts", 64'(b_pkts), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
